// File: rtl/cpu64_pkg.sv
// cpu64_pkg
//   Shared definitions for the cpu64 memory-side blocks.
//   - SRC_IMEM / SRC_DMEM : source IDs stored per granted transaction
//   - arb_state_e         : instruction/data arbiter FSM encoding
// Optional feature macro used by users of this package: CPU64_ARB_RR_EN.
package cpu64_pkg;

    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cpu64_src_id_fifo.sv
// cpu64_src_id_fifo
//   1-bit-wide synchronous FIFO holding the source ID of every granted
//   memory transaction, in grant order.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i     write one ID (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   data_o             head entry
//   full_o, empty_o    occupancy flags
//   count_o            current occupancy
module cpu64_src_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       data_i,
    input  logic                       pop_i,
    output logic                       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu64_imem_dmem_arbiter.sv
// cpu64_imem_dmem_arbiter
//   Shares one OBI memory port between the fetch stage (imem, read-only)
//   and the load/store unit (dmem, read/write). A request that has been
//   presented but not granted stays locked to its host. Granted source IDs
//   are queued in order and used to steer each rvalid/rdata back.
// Build option: define CPU64_ARB_RR_EN for round-robin arbitration;
//   otherwise data wins contention, with a starvation counter that forces
//   an instruction win after STARVE_LIMIT consecutive data grants.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   imem_req/addr_i, imem_gnt/rvalid/rdata_o       instruction host
//   dmem_req/we/be/addr/wdata_i, dmem_gnt/rvalid/rdata_o  data host
//   mem_req/we/be/addr/wdata_o, mem_gnt/rvalid/rdata_i    memory port
//   outstanding_o                      granted-but-unanswered count
//   busy_o                             FIFO non-empty or lock held
//   arb_state_o                        FSM state (debug)
// Handshake: a request is transferred on a cycle where req and gnt are
//   both high; once req is presented, the arbiter keeps the same host and
//   payload on the memory port until gnt. Responses arrive in grant order.
module cpu64_imem_dmem_arbiter
    import cpu64_pkg::*;
#(
    parameter int VADDR           = 39,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               imem_req_i,
    input  logic [VADDR-1:0]                   imem_addr_i,
    output logic                               imem_gnt_o,
    output logic                               imem_rvalid_o,
    output logic [DATA_W-1:0]                  imem_rdata_o,
    input  logic                               dmem_req_i,
    input  logic                               dmem_we_i,
    input  logic [DATA_W/8-1:0]                dmem_be_i,
    input  logic [VADDR-1:0]                   dmem_addr_i,
    input  logic [DATA_W-1:0]                  dmem_wdata_i,
    output logic                               dmem_gnt_o,
    output logic                               dmem_rvalid_o,
    output logic [DATA_W-1:0]                  dmem_rdata_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [DATA_W/8-1:0]                mem_be_o,
    output logic [VADDR-1:0]                   mem_addr_o,
    output logic [DATA_W-1:0]                  mem_wdata_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic [DATA_W-1:0]                  mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               busy_o,
    output logic [1:0]                         arb_state_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e    state_q;
    logic          arb_dmem;
    logic          sel_dmem;
    logic          sel_req;
    logic          sel_gnt;
    logic          rsp_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic [CW-1:0] fifo_count;

`ifdef CPU64_ARB_RR_EN
    logic prio_imem_q;  // 1: instruction wins the next contention

    assign arb_dmem = dmem_req_i & (~imem_req_i | ~prio_imem_q);
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt_q;

    assign arb_dmem = dmem_req_i & (~imem_req_i | (starve_cnt_q != SW'(STARVE_LIMIT)));
`endif

    always_comb begin
        sel_dmem = arb_dmem;
        case (state_q)
            ARB_LOCK_I: sel_dmem = 1'b0;
            ARB_LOCK_D: sel_dmem = 1'b1;
            default:    sel_dmem = arb_dmem;
        endcase
    end

    assign sel_req     = sel_dmem ? dmem_req_i : imem_req_i;
    // A full ID FIFO blocks new requests so every grant has a slot.
    assign mem_req_o   = sel_req & ~fifo_full & ~rst_i;
    assign mem_we_o    = sel_dmem & dmem_we_i;
    assign mem_be_o    = sel_dmem ? dmem_be_i : '1;
    assign mem_addr_o  = sel_dmem ? dmem_addr_i : imem_addr_i;
    assign mem_wdata_o = sel_dmem ? dmem_wdata_i : '0;

    assign sel_gnt    = mem_gnt_i & mem_req_o;
    assign imem_gnt_o = sel_gnt & ~sel_dmem;
    assign dmem_gnt_o = sel_gnt & sel_dmem;

    // A stray rvalid with nothing outstanding is dropped.
    assign rsp_pop       = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign imem_rvalid_o = rsp_pop & (fifo_head == SRC_IMEM);
    assign dmem_rvalid_o = rsp_pop & (fifo_head == SRC_DMEM);
    assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;

    assign outstanding_o = rst_i ? '0 : fifo_count;
    assign busy_o        = ~rst_i & (~fifo_empty | (state_q != ARB_IDLE));
    assign arb_state_o   = state_q;

    cpu64_src_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (sel_gnt),
        .data_i  (sel_dmem ? SRC_DMEM : SRC_IMEM),
        .pop_i   (rsp_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
`ifdef CPU64_ARB_RR_EN
            prio_imem_q <= 1'b1;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q <= sel_dmem ? ARB_LOCK_D : ARB_LOCK_I;
                    end
                end
                ARB_LOCK_I, ARB_LOCK_D: begin
                    if (mem_gnt_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
`ifdef CPU64_ARB_RR_EN
            if (imem_gnt_o) begin
                prio_imem_q <= 1'b0;
            end else if (dmem_gnt_o) begin
                prio_imem_q <= 1'b1;
            end
`else
            // Counts data grants that overtook a waiting instruction fetch.
            if (!imem_req_i || imem_gnt_o) begin
                starve_cnt_q <= '0;
            end else if (dmem_gnt_o && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mem_rvalid_i && fifo_empty))
            else $error("arbiter: mem_rvalid_i with no outstanding transaction");
        end
    end
`endif

endmodule

// File: tb/tb_cpu64_imem_dmem_arbiter.sv
// tb_cpu64_imem_dmem_arbiter
//   Directed scenarios followed by randomized OBI traffic, checked against
//   a transaction-level model: a queue of issued source IDs, the host whose
//   request is pending, and the arbitration priority rule.
module tb_cpu64_imem_dmem_arbiter;
    import cpu64_pkg::*;

    localparam int VADDR = 39;
    localparam int DATA_W = 32;
    localparam int MAXO = 2;
    localparam int SL = 4;

    logic              clk;
    logic              rst;
    logic              ireq;
    logic [VADDR-1:0]  iaddr;
    logic              igrant, irv;
    logic [DATA_W-1:0] ird;
    logic              dreq, dwe;
    logic [3:0]        dbe;
    logic [VADDR-1:0]  daddr;
    logic [DATA_W-1:0] dwdata;
    logic              dgrant, drv;
    logic [DATA_W-1:0] drd;
    logic              mreq, mwe;
    logic [3:0]        mbe;
    logic [VADDR-1:0]  maddr;
    logic [DATA_W-1:0] mwdata;
    logic              gnt, rv;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        outst;
    logic              busy;
    logic [1:0]        st;

    cpu64_imem_dmem_arbiter #(
        .VADDR(VADDR), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(ireq), .imem_addr_i(iaddr), .imem_gnt_o(igrant),
        .imem_rvalid_o(irv), .imem_rdata_o(ird),
        .dmem_req_i(dreq), .dmem_we_i(dwe), .dmem_be_i(dbe), .dmem_addr_i(daddr),
        .dmem_wdata_i(dwdata), .dmem_gnt_o(dgrant), .dmem_rvalid_o(drv), .dmem_rdata_o(drd),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr),
        .mem_wdata_o(mwdata), .mem_gnt_i(gnt), .mem_rvalid_i(rv), .mem_rdata_i(rdata),
        .outstanding_o(outst), .busy_o(busy), .arb_state_o(st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model state
    int mq[$];       // source IDs in grant order: 0 instr, 1 data
    int pend = -1;   // host with an ungranted presented request
    int run = 0;     // consecutive data grants while instr waits
    int prio_i = 1;  // round-robin: instr wins next contention

    // values sampled in the last cycle
    logic              obs_ig, obs_dg, obs_req, obs_irv, obs_drv, obs_busy;
    logic [VADDR-1:0]  obs_addr;
    logic [DATA_W-1:0] obs_ird, obs_drd;
    logic [1:0]        obs_out, obs_state;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate one cycle: sample, compare to the model, clock, advance model.
    task automatic run_cycle(input string tag);
        int  win;
        bit  full, e_req, e_ig, e_dg, pop;
        int  head;
        #2;
        obs_ig = igrant; obs_dg = dgrant; obs_req = mreq; obs_irv = irv; obs_drv = drv;
        obs_busy = busy; obs_addr = maddr; obs_ird = ird; obs_drd = drd;
        obs_out = outst; obs_state = st;
        if (rst) begin
            chk({tag, "_rst_req"}, mreq, 0);
            chk({tag, "_rst_ig"}, igrant, 0);
            chk({tag, "_rst_dg"}, dgrant, 0);
            chk({tag, "_rst_irv"}, irv, 0);
            chk({tag, "_rst_drv"}, drv, 0);
            chk({tag, "_rst_out"}, outst, 0);
            chk({tag, "_rst_busy"}, busy, 0);
            mq.delete();
            pend = -1;
            run = 0;
            prio_i = 1;
        end else begin
            full = (mq.size() == MAXO);
            win = -1;
            if (pend != -1) win = pend;
            else if (!full) begin
`ifdef CPU64_ARB_RR_EN
                if (ireq && dreq) win = prio_i ? 0 : 1;
`else
                if (ireq && dreq) win = (run == SL) ? 0 : 1;
`endif
                else if (ireq) win = 0;
                else if (dreq) win = 1;
            end
            e_req = (win != -1) && !full;
            e_ig = e_req && gnt && (win == 0);
            e_dg = e_req && gnt && (win == 1);
            pop = rv && (mq.size() > 0);
            head = pop ? mq[0] : -1;
            chk({tag, "_mem_req"}, mreq, e_req);
            chk({tag, "_imem_gnt"}, igrant, e_ig);
            chk({tag, "_dmem_gnt"}, dgrant, e_dg);
            chk({tag, "_outstanding"}, outst, mq.size());
            chk({tag, "_busy"}, busy, (mq.size() > 0) || (pend != -1));
            chk({tag, "_imem_rvalid"}, irv, head == 0);
            chk({tag, "_dmem_rvalid"}, drv, head == 1);
            chk({tag, "_imem_rdata"}, ird, (head == 0) ? rdata : 32'h0);
            chk({tag, "_dmem_rdata"}, drd, (head == 1) ? rdata : 32'h0);
            if (e_req) begin
                chk({tag, "_mem_addr"}, maddr, (win == 1) ? daddr : iaddr);
                chk({tag, "_mem_we"}, mwe, (win == 1) ? dwe : 1'b0);
                chk({tag, "_mem_be"}, mbe, (win == 1) ? dbe : 4'hf);
                chk({tag, "_mem_wdata"}, mwdata, (win == 1) ? dwdata : 32'h0);
            end
            if (pop) void'(mq.pop_front());
            if (e_ig) mq.push_back(0);
            if (e_dg) mq.push_back(1);
            pend = (e_req && !gnt) ? win : -1;
            if (!ireq || e_ig) run = 0;
            else if (e_dg && run < SL) run++;
            if (e_ig) prio_i = 0;
            else if (e_dg) prio_i = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        iaddr = VADDR'({$urandom, $urandom});
        daddr = VADDR'({$urandom, $urandom});
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15));
        dwdata = $urandom;
        rdata = $urandom;
    endtask

    string seq;
    bit i_hold, d_hold;

    initial begin
        rst = 1; ireq = 0; dreq = 0; gnt = 0; rv = 0;
        iaddr = '0; daddr = '0; dwe = 0; dbe = '0; dwdata = '0; rdata = '0;

        run_cycle("reset0");
        ireq = 1; dreq = 1; gnt = 1;
        run_cycle("reset1");
        ireq = 0; dreq = 0; gnt = 0;
        rst = 0;
        run_cycle("post_reset");
        chk("post_reset_state", obs_state, ARB_IDLE);

        // Contention with immediate grants and single-cycle responses.
`ifdef CPU64_ARB_RR_EN
        seq = "IDIDIDIDID";
`else
        seq = "DDDDIDDDDI";
`endif
        for (int i = 0; i < 11; i++) begin
            rand_payload();
            ireq = (i < 10); dreq = (i < 10); gnt = 1; rv = (i > 0);
            run_cycle("seq");
            if (i < 10) begin
                chk("seq_igrant", obs_ig, seq[i] == "I");
                chk("seq_dgrant", obs_dg, seq[i] == "D");
            end
            if (i > 0) begin
                chk("seq_irvalid", obs_irv, seq[i-1] == "I");
                chk("seq_drvalid", obs_drv, seq[i-1] == "D");
            end
        end

        // Lock: instruction presented first, data arrives while waiting.
        ireq = 1; iaddr = 39'h1000; dreq = 0; gnt = 0; rv = 0; dwe = 1; dbe = 4'h3;
        run_cycle("lock_c0");
        chk("lock_c0_addr", obs_addr, 39'h1000);
        chk("lock_c0_dgnt", obs_dg, 0);
        dreq = 1; daddr = 39'h2000;
        run_cycle("lock_c1");
        chk("lock_c1_addr", obs_addr, 39'h1000);
        chk("lock_c1_dgnt", obs_dg, 0);
        chk("lock_c1_state", obs_state, ARB_LOCK_I);
        run_cycle("lock_c2");
        chk("lock_c2_addr", obs_addr, 39'h1000);
        chk("lock_c2_dgnt", obs_dg, 0);
        gnt = 1;
        run_cycle("lock_c3");
        chk("lock_c3_igrant", obs_ig, 1);
        chk("lock_c3_dgnt", obs_dg, 0);
        ireq = 0;
        run_cycle("lock_c4");
        chk("lock_c4_dgnt", obs_dg, 1);
        chk("lock_c4_addr", obs_addr, 39'h2000);

        // FIFO full: no request until a response frees a slot.
        daddr = 39'h3000;
        run_cycle("full_c5");
        chk("full_req", obs_req, 0);
        chk("full_dgnt", obs_dg, 0);
        chk("full_outstanding", obs_out, 2);
        rv = 1; rdata = 32'hDEADBEEF;
        run_cycle("full_c6");
        chk("full_rsp_irvalid", obs_irv, 1);
        chk("full_rsp_irdata", obs_ird, 32'hDEADBEEF);
        chk("full_rsp_drdata", obs_drd, 0);
        rv = 0;
        run_cycle("full_c7");
        chk("third_grant", obs_dg, 1);
        chk("third_addr", obs_addr, 39'h3000);

        // Drain to one entry, then grant and respond in the same cycle.
        dreq = 0; rv = 1; rdata = 32'h1111_2222;
        run_cycle("pp_c8");
        chk("pp_c8_drvalid", obs_drv, 1);
        ireq = 1; iaddr = 39'h4000; gnt = 1; rv = 1; rdata = 32'h3333_4444;
        run_cycle("pp_c9");
        chk("pp_c9_igrant", obs_ig, 1);
        chk("pp_c9_drvalid", obs_drv, 1);
        chk("pp_c9_irvalid", obs_irv, 0);
        chk("pp_c9_outstanding", obs_out, 1);
        ireq = 0; dreq = 1; daddr = 39'h5000; rv = 0;
        run_cycle("pp_c10");
        chk("pp_c10_outstanding", obs_out, 1);
        chk("pp_c10_dgnt", obs_dg, 1);

        // Reset with two transactions outstanding.
        rst = 1;
        run_cycle("mid_reset");
        chk("mid_reset_dgnt", obs_dg, 0);
        rst = 0; dreq = 0; gnt = 0;
        run_cycle("after_reset");
        chk("after_reset_outstanding", obs_out, 0);
        chk("after_reset_busy", obs_busy, 0);
        chk("after_reset_state", obs_state, ARB_IDLE);

        // Randomized traffic; hosts keep a presented request until granted.
        i_hold = 0; d_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!i_hold) begin
                ireq = 1'($urandom_range(0, 1));
                iaddr = VADDR'({$urandom, $urandom});
            end
            if (!d_hold) begin
                dreq = 1'($urandom_range(0, 2) != 0);
                daddr = VADDR'({$urandom, $urandom});
                dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom_range(0, 15));
                dwdata = $urandom;
            end
            gnt = 1'($urandom_range(0, 3) != 0);
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            rdata = $urandom;
            run_cycle("rand");
            i_hold = ireq && !obs_ig;
            d_hold = dreq && !obs_dg;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu64_imem_dmem_arbiter.md
Name: cpu64_imem_dmem_arbiter

Overview:
- Shares one OBI memory port between the fetch stage (instruction host, read-only) and the load/store unit (data host, read/write).
- Arbitrates each request and locks the selection until grant.
- Tracks up to MAX_OUTSTANDING granted transactions in an in-order source-ID FIFO, and routes each rvalid/rdata back to the host that issued it.
- Sits between the fetch/LSU OBI host drivers and the unified memory/cache port.

Parameters:
- VADDR, 39, address width of both hosts and the memory port.
- DATA_W, 32, data width of both hosts and the memory port.
- MAX_OUTSTANDING, 2, depth of the source-ID FIFO; must be at least 1.
- STARVE_LIMIT, 4, consecutive data grants allowed while instruction is requesting before instruction is forced to win; must be at least 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- imem_req_i  in  1  instruction request
- imem_addr_i  in  VADDR  instruction address
- imem_gnt_o  out  1  instruction grant
- imem_rvalid_o  out  1  instruction response valid
- imem_rdata_o  out  DATA_W  instruction response data
- dmem_req_i  in  1  data request
- dmem_we_i  in  1  data write enable
- dmem_be_i  in  DATA_W/8  data byte enables
- dmem_addr_i  in  VADDR  data address
- dmem_wdata_i  in  DATA_W  data write data
- dmem_gnt_o  out  1  data grant
- dmem_rvalid_o  out  1  data response valid (reads and writes)
- dmem_rdata_o  out  DATA_W  data response data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_addr_o  out  VADDR  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
- busy_o  out  1  high when FIFO non-empty or lock held

Behaviour:
- Reset (rst_i high at posedge): FSM to IDLE, FIFO empty, starvation counter 0.
- Outputs driven combinationally from state and inputs. During and immediately after reset:
  - all gnt/rvalid/mem_req outputs read 0;
  - outstanding_o = 0, busy_o = 0.
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o:
  - combinational mux of the selected host;
  - instruction host drives we=0, be=all-ones, wdata=0.
- FIFO full: mem_req_o=0 and both gnt outputs 0, regardless of host requests.
- Grant routing: sel_gnt = mem_gnt_i & mem_req_o goes to the selected host only; the other host's gnt is 0.
- FSM states:
  - IDLE: selection from arbitration. If mem_req_o=1 and mem_gnt_i=0, move to LOCK_I or LOCK_D per the winner.
  - LOCK_I / LOCK_D: selection forced to the locked host. Return to IDLE on mem_gnt_i.
  - OBI rule: a presented request is never withdrawn or switched by the arbiter before grant.
- Arbitration (IDLE only):
  - data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case instruction wins;
  - a single requester always wins.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each data grant while imem_req_i=1;
  - clears on any instruction grant, or when imem_req_i=0.
- Each grant pushes its source ID (0=instr, 1=data) into the FIFO.
- Each mem_rvalid_i pops the head:
  - rvalid/rdata go to the head's host only; the other host's rdata is 0;
  - push and pop in the same cycle keep occupancy unchanged.
- mem_rvalid_i with an empty FIFO is a protocol error:
  - ignored, with no output pulse;
  - simulation-only assertion fires.
- Responses are returned strictly in grant order; the arbiter does not filter responses.
- Fetch squash/redirect does not cancel in-flight responses; the fetch stage drops stale data itself.
- Reset mid-transaction clears the FIFO; the memory side is reset in the same cycle.

Optional Feature:
- Macro CPU64_ARB_RR_EN.
- Defined:
  - round-robin arbitration: after a grant, the other host gets priority on the next contention;
  - starve_cnt is removed and STARVE_LIMIT is ignored.
- Undefined: data-priority with the starvation counter, as above.
- Lock, FIFO and routing behaviour are identical in both builds.

Decomposition:
- Shared package cpu64_pkg:
  - source-ID constants SRC_IMEM=1'b0, SRC_DMEM=1'b1;
  - arbiter FSM state encodings ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D.
- One sub-module: cpu64_src_id_fifo, a parameterised 1-bit-wide synchronous FIFO with push/pop, full/empty and count.

Test Plan:
- Both hosts request continuously, mem_gnt_i=1, rvalid one cycle after each grant, STARVE_LIMIT=4 (RR_EN undefined):
  - grant sequence D,D,D,D,I,D,D,D,D,I;
  - each response arrives on the host that issued it.
- Instruction requests addr 0x1000, mem_gnt_i held 0 for 3 cycles, data requests at cycle 1:
  - mem_addr_o stays 0x1000 and dmem_gnt_o=0 throughout;
  - instruction is granted at cycle 3, data the cycle after.
- MAX_OUTSTANDING=2, mem_gnt_i=1, no rvalid: two grants, then mem_req_o=0 and outstanding_o=2. Then one rvalid with rdata 0xDEADBEEF:
  - it is delivered to the first-granted host;
  - next cycle a third grant occurs.
- Same-cycle grant and rvalid with FIFO at 1: outstanding_o stays 1, and the response routes to the older ID.
- Reset asserted with 2 outstanding: next cycle outstanding_o=0, busy_o=0, state IDLE.
- CPU64_ARB_RR_EN defined, both hosts requesting: grants alternate I,D,I,D (instruction first from reset).
